// File: rtl/dac_cal_pipe.sv
// rtl/dac_cal_pipe.sv - multi-channel piecewise-affine DAC code calibrator, 3-stage pipeline, double-buffered coefficients
// Optional feature macro: DAC_CAL_SAT_CNT_EN (adds sat_clr input and 16-bit sat_count output)
module dac_cal_pipe #(
  parameter int RAW_WIDTH  = 10,
  parameter int OUT_WIDTH  = 10,
  parameter int CHANNELS   = 4,
  parameter int SEG_BITS   = 3,
  parameter int FRACT_BITS = 8,
  parameter int A0_WIDTH   = 8,
  parameter int A1_WIDTH   = 12,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH_W-1:0]            in_chan,
  input  logic [RAW_WIDTH-1:0]       in_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_chan,
  output logic [OUT_WIDTH-1:0]       out_code,
  output logic                       out_sat,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_chan,
  input  logic [SEG_BITS-1:0]        cfg_seg,
  input  logic signed [A0_WIDTH-1:0] cfg_a0,
  input  logic [A1_WIDTH-1:0]        cfg_a1,
  input  logic                       cfg_commit,
  output logic                       cfg_busy
`ifdef DAC_CAL_SAT_CNT_EN
  ,
  input  logic                       sat_clr,
  output logic [15:0]                sat_count
`endif
);

  localparam int SEGMENTS = 2 ** SEG_BITS;
  localparam int DEPTH    = CHANNELS * SEGMENTS;
  localparam int AW       = CH_W + SEG_BITS;
  localparam int PW       = A1_WIDTH + RAW_WIDTH;
  localparam int SW       = ((PW > A0_WIDTH) ? PW : A0_WIDTH) + 2;
  localparam logic [A1_WIDTH-1:0] A1_ONE = A1_WIDTH'(1) << FRACT_BITS;
  localparam logic signed [SW-1:0] OUT_MAX = SW'((64'd1 << OUT_WIDTH) - 64'd1);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t state, state_nx;
  logic   bank_sel;
  logic   stall, accept, cfg_ok;

  logic signed [A0_WIDTH-1:0] a0_mem [0:1][0:DEPTH-1];
  logic [A1_WIDTH-1:0]        a1_mem [0:1][0:DEPTH-1];

  logic [CH_W-1:0]     rd_chan;
  logic [SEG_BITS-1:0] rd_seg;
  logic [AW-1:0]       rd_addr, wr_addr;

  logic                       v1, en1;
  logic [RAW_WIDTH-1:0]       code1;
  logic [CH_W-1:0]            chan1;
  logic signed [A0_WIDTH-1:0] a0_1;
  logic [A1_WIDTH-1:0]        a1_1;

  logic                       v2, en2;
  logic [RAW_WIDTH-1:0]       code2;
  logic [CH_W-1:0]            chan2;
  logic signed [A0_WIDTH-1:0] a0_2;
  logic [PW-1:0]              prod2;

  logic signed [SW-1:0] shifted, sum;
  logic [OUT_WIDTH-1:0] res_code;
  logic                 res_sat;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & (state == RUN);
  assign cfg_busy = (state != RUN);
  assign accept   = in_valid & in_ready;
  assign rd_addr  = {rd_chan, rd_seg};
  assign wr_addr  = {cfg_chan, cfg_seg};
  assign cfg_ok   = (32'(cfg_chan) < CHANNELS);

  // Out-of-range channels fold onto the last channel; segment is the top code bits
  always_comb begin
    rd_chan = in_chan;
    if (32'(in_chan) >= CHANNELS) rd_chan = CH_W'(CHANNELS - 1);
    rd_seg = in_code[RAW_WIDTH-1 -: SEG_BITS];
  end

  // Coefficient banks: writes always target whichever bank is shadow this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          a0_mem[b][i] <= '0;
          a1_mem[b][i] <= A1_ONE;
        end
      end
    end else if (cfg_we && cfg_ok) begin
      a0_mem[~bank_sel][wr_addr] <= cfg_a0;
      a1_mem[~bank_sel][wr_addr] <= cfg_a1;
    end
  end

  // Commit state register and bank pointer; the swap happens at the end of SWAP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      bank_sel <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SWAP) bank_sel <= ~bank_sel;
    end
  end

  // Commit next-state: drain the pipeline before swapping so no sample mixes tables
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (cfg_commit) state_nx = DRAIN;
      DRAIN:   if (!v1 && !v2 && !out_valid) state_nx = SWAP;
      SWAP:    state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Final stage arithmetic: scale, add offset, clamp to the output range or bypass
  always_comb begin
    shifted  = SW'(prod2 >> FRACT_BITS);
    sum      = shifted + SW'(a0_2);
    res_sat  = 1'b0;
    res_code = sum[OUT_WIDTH-1:0];
    if (!en2) begin
      res_code = OUT_WIDTH'(code2);
    end else if (sum < 0) begin
      res_code = '0;
      res_sat  = 1'b1;
    end else if (sum > OUT_MAX) begin
      res_code = '1;
      res_sat  = 1'b1;
    end
  end

  // Three-stage pipeline; a stall freezes every stage together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      en1       <= 1'b0;
      code1     <= '0;
      chan1     <= '0;
      a0_1      <= '0;
      a1_1      <= '0;
      v2        <= 1'b0;
      en2       <= 1'b0;
      code2     <= '0;
      chan2     <= '0;
      a0_2      <= '0;
      prod2     <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_chan  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        code1 <= in_code;
        chan1 <= rd_chan;
        en1   <= enable;
        a0_1  <= a0_mem[bank_sel][rd_addr];
        a1_1  <= a1_mem[bank_sel][rd_addr];
      end
      v2 <= v1;
      if (v1) begin
        prod2 <= PW'(a1_1) * PW'(code1);
        a0_2  <= a0_1;
        code2 <= code1;
        chan2 <= chan1;
        en2   <= en1;
      end
      out_valid <= v2;
      if (v2) begin
        out_code <= res_code;
        out_sat  <= res_sat;
        out_chan <= chan2;
      end
    end
  end

`ifdef DAC_CAL_SAT_CNT_EN
  // Saturation event counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_cal_pipe.sv
// tb/tb_dac_cal_pipe.sv - self-checking bench for dac_cal_pipe with a table-level reference model
module tb_dac_cal_pipe;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_chan;
  logic [9:0]        in_code;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_chan;
  logic [9:0]        out_code;
  logic              out_sat;
  logic              cfg_we;
  logic [1:0]        cfg_chan;
  logic [2:0]        cfg_seg;
  logic signed [7:0] cfg_a0;
  logic [11:0]       cfg_a1;
  logic              cfg_commit;
  logic              cfg_busy;
`ifdef DAC_CAL_SAT_CNT_EN
  logic              sat_clr;
  logic [15:0]       sat_count;
`endif

  dac_cal_pipe dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_code(out_code), .out_sat(out_sat),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_seg(cfg_seg),
    .cfg_a0(cfg_a0), .cfg_a1(cfg_a1), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
`ifdef DAC_CAL_SAT_CNT_EN
    , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int chan;
    int code;
    int sat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   m_a0 [2][4][8];
  int   m_a1 [2][4][8];
  int   m_act;
  int   m_satcnt;
  int   cyc;
  int   errors;
  int   checks;
  bit   check_lat;
  bit   acc_now;
  bit   hold_pend;
  logic [9:0] h_code;
  logic [1:0] h_chan;
  logic       h_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 4; c++)
        for (int s = 0; s < 8; s++) begin
          m_a0[b][c][s] = 0;
          m_a1[b][c][s] = 256;
        end
    m_act = 0;
  endfunction

  // Calibrated value from the active table using plain integer arithmetic
  function automatic exp_t calc(input int ch, input int code, input bit en, input int acc);
    exp_t e;
    int   seg, v;
    if (ch > 3) ch = 3;
    e.chan = ch;
    e.acc  = acc;
    e.sat  = 0;
    if (!en) begin
      e.code = code;
    end else begin
      seg = code / 128;
      v = m_a0[m_act][ch][seg] + (m_a1[m_act][ch][seg] * code) / 256;
      if (v < 0) begin
        e.code = 0;
        e.sat  = 1;
      end else if (v > 1023) begin
        e.code = 1023;
        e.sat  = 1;
      end else begin
        e.code = v;
      end
    end
    return e;
  endfunction

  // One clock cycle: check outputs, record handshakes and table updates, advance
  task automatic tick();
    exp_t e;
    #1;
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_code", out_code, h_code);
      chk("hold_chan", out_chan, h_chan);
      chk("hold_sat", out_sat, h_sat);
    end
    hold_pend = out_valid && !out_ready;
    h_code = out_code;
    h_chan = out_chan;
    h_sat  = out_sat;
    if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_code", out_code, e.code);
        chk("out_chan", out_chan, e.chan);
        chk("out_sat", out_sat, e.sat);
        if (check_lat) chk("latency", cyc - e.acc, 3);
        if (e.sat != 0) m_satcnt++;
      end
    end
    acc_now = in_valid && in_ready;
    if (acc_now) sb.push_back(calc(int'(in_chan), int'(in_code), enable, cyc));
    if (cfg_we) begin
      m_a0[1-m_act][cfg_chan][cfg_seg] = int'(cfg_a0);
      m_a1[1-m_act][cfg_chan][cfg_seg] = int'(cfg_a1);
    end
    if (cfg_commit) m_act = 1 - m_act;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int ch, input int code, input bit en);
    int n;
    in_valid = 1'b1;
    in_chan  = 2'(ch);
    in_code  = 10'(code);
    enable   = en;
    n = 0;
    acc_now = 1'b0;
    while (!acc_now && n < 50) begin
      tick();
      n++;
    end
    if (!acc_now) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    enable   = 1'b1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() > 0 || out_valid) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic write(input int ch, input int seg, input int a0, input int a1);
    cfg_we   = 1'b1;
    cfg_chan = 2'(ch);
    cfg_seg  = 3'(seg);
    cfg_a0   = 8'(a0);
    cfg_a1   = 12'(a1);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic commit();
    int n;
    chk("busy_pre", cfg_busy, 0);
    cfg_commit = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("busy_set", cfg_busy, 1);
    chk("in_ready_drain", in_ready, 0);
    n = 0;
    while (cfg_busy && n < 20) begin
      tick();
      n++;
    end
    chk("busy_clear", cfg_busy, 0);
    chk("commit_len", (n <= 4) ? 1 : 0, 1);
  endtask

  initial begin
    int remaining;
    errors = 0; checks = 0; cyc = 0; m_satcnt = 0;
    check_lat = 1'b0; hold_pend = 1'b0; acc_now = 1'b0;
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_chan = '0; in_code = '0;
    out_ready = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_seg = '0; cfg_a0 = '0;
    cfg_a1 = '0; cfg_commit = 1'b0;
`ifdef DAC_CAL_SAT_CNT_EN
    sat_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Identity pass-through with exact 3-cycle latency
    check_lat = 1'b1;
    send(0, 0, 1);
    send(0, 300, 1);
    send(0, 1023, 1);
    drain();
    check_lat = 1'b0;

    // Non-identity segment on ch1; ch0 stays identity
    write(1, 2, -5, 260);
    commit();
    send(1, 300, 1);
    send(0, 300, 1);
    drain();

    // Clamp at both ends on ch2
    write(2, 7, 0, 300);
    write(2, 0, -10, 256);
    commit();
    send(2, 1023, 1);
    send(2, 2, 1);
    drain();

    // Burst of 6 with a 5-cycle output stall
    remaining = 6;
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 3 && i < 8);
      in_valid  = (remaining > 0);
      in_chan   = 2'($urandom_range(0, 3));
      in_code   = 10'($urandom_range(0, 1023));
      tick();
      if (acc_now) remaining--;
    end
    chk("burst_sent", remaining, 0);
    drain();

    // Commit with three samples in flight
    write(3, 3, 7, 200);
    send(3, 400, 1);
    send(3, 401, 1);
    send(3, 402, 1);
    commit();
    send(3, 400, 1);
    drain();

    // Randomized traffic, tables and commits
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++)
        write($urandom_range(0, 3), $urandom_range(0, 7),
              int'($urandom_range(0, 255)) - 128, $urandom_range(0, 4095));
      for (int i = 0; i < 60; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_chan   = 2'($urandom_range(0, 3));
        in_code   = 10'($urandom_range(0, 1023));
        enable    = ($urandom_range(0, 7) != 0);
        tick();
      end
      enable = 1'b1;
      drain();
      commit();
    end

    // Bypass under non-identity coefficients
    write(1, 4, 20, 300);
    commit();
    send(1, 517, 0);
    drain();
`ifdef DAC_CAL_SAT_CNT_EN
    chk("sat_count", sat_count, m_satcnt);
`endif

    // Reset mid-burst
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_chan  = 2'(1);
      in_code  = 10'($urandom_range(0, 1023));
      tick();
    end
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_code", out_code, 0);
    chk("midrst_out_chan", out_chan, 0);
    chk("midrst_out_sat", out_sat, 0);
    chk("midrst_busy", cfg_busy, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    model_reset();
    m_satcnt  = 0;
    hold_pend = 1'b0;
    send(1, 517, 1);
    send(1, 300, 1);
    send(2, 1023, 1);
    drain();
`ifdef DAC_CAL_SAT_CNT_EN
    chk("sat_count_rst", sat_count, m_satcnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
